simple_ram: RTL and testbench

SIMPLE_RAM -- requirements
Module: simple_ram

---
 rtl/simple_ram.sv | 41 ++++
 tb/tb_simple_ram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/simple_ram.sv
// Simple dual-port RAM: registered write port, combinational read port.
// Define SIMPLE_RAM_WRITE_BYPASS_EN for write-first forwarding onto q.
module simple_ram #(
  parameter int width   = 8,
  parameter int widthad = 4
) (
  input  logic               clk,
  input  logic [widthad-1:0] wraddress,
  input  logic               wren,
  input  logic [width-1:0]   data,
  input  logic [widthad-1:0] rdaddress,
  output logic [width-1:0]   q,
  input  logic               rst
);

  localparam int depth = 2 ** widthad;

  logic [width-1:0] mem [0:depth-1] = '{default: '0};

  // Reset wipes every word and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wren) begin
      mem[wraddress] <= data;
    end
  end

`ifdef SIMPLE_RAM_WRITE_BYPASS_EN
  logic w_hit;

  assign w_hit = wren && !rst &&
                 (wraddress == rdaddress);
  assign q     = w_hit ? data : mem[rdaddress];
`else
  assign q = mem[rdaddress];
`endif

endmodule

// File: tb/tb_simple_ram.sv
// Directed bench for simple_ram: an 8x16 instance
// driven from a vector table, and a 30x4 instance.
module tb_simple_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wren;
  logic [3:0] wa;
  logic [3:0] ra;
  logic [7:0] d;
  logic [7:0] q;

  logic        c_rst;
  logic        c_wren;
  logic [1:0]  c_wa;
  logic [1:0]  c_ra;
  logic [29:0] c_d;
  logic [29:0] c_q;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  simple_ram #(.width(8), .widthad(4)) u8 (
    .clk(clk), .wraddress(wa), .wren(wren),
    .data(d), .rdaddress(ra), .q(q), .rst(rst)
  );

  simple_ram #(.width(30), .widthad(2)) u30 (
    .clk(clk), .wraddress(c_wa), .wren(c_wren),
    .data(c_d), .rdaddress(c_ra), .q(c_q),
    .rst(c_rst)
  );

  typedef struct {
    logic       rst;
    logic       wren;
    logic [3:0] wa;
    logic [7:0] d;
    logic [3:0] ra;
    logic [7:0] pre;
    logic [7:0] post;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Drive one cycle; check q before and after the edge.
  task automatic run(input vec_t v, input string nm);
    logic [7:0] e_pre;
    @(negedge clk);
    rst  = v.rst;
    wren = v.wren;
    wa   = v.wa;
    d    = v.d;
    ra   = v.ra;
    e_pre = v.pre;
`ifdef SIMPLE_RAM_WRITE_BYPASS_EN
    if (v.wren && !v.rst && v.wa == v.ra)
      e_pre = v.d;
`endif
    #1;
    chk({nm, " pre"}, {24'h0, q}, {24'h0, e_pre});
    @(posedge clk);
    #1;
    chk({nm, " post"}, {24'h0, q}, {24'h0, v.post});
  endtask

  task automatic idle_read(input logic [3:0] a,
                           input logic [7:0] e,
                           input string nm);
    @(negedge clk);
    rst  = 1'b0;
    wren = 1'b0;
    ra   = a;
    #1;
    chk(nm, {24'h0, q}, {24'h0, e});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) u30.mem[i] = '0;
    rst = 1'b0; wren = 1'b0;
    wa = '0; ra = '0; d = '0;
    c_rst = 1'b0; c_wren = 1'b0;
    c_wa = '0; c_ra = '0; c_d = '0;

    //       rst   wren  wa     d      ra     pre    post
    vt[0] = '{1'b0, 1'b1, 4'd3, 8'hA5, 4'd3, 8'h00, 8'hA5};
    vt[1] = '{1'b0, 1'b0, 4'd0, 8'h00, 4'd4, 8'h00, 8'h00};
    vt[2] = '{1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'hA5, 8'hA5};
    vt[3] = '{1'b0, 1'b1, 4'd7, 8'h11, 4'd7, 8'h00, 8'h11};
    vt[4] = '{1'b0, 1'b1, 4'd7, 8'h3C, 4'd7, 8'h11, 8'h3C};
    vt[5] = '{1'b0, 1'b0, 4'd7, 8'hFF, 4'd7, 8'h3C, 8'h3C};

    #1;
    chk("initial q", {24'h0, q}, 32'h0);

    for (int i = 0; i < 6; i++)
      run(vt[i], $sformatf("vec%0d", i));

    // Fill every word with addr+1.
    for (int a = 0; a < 16; a++)
      run('{1'b0, 1'b1, 4'(a), 8'(a + 1), 4'(a),
            (a == 3) ? 8'hA5 : (a == 7) ? 8'h3C : 8'h00,
            8'(a + 1)},
          $sformatf("fill%0d", a));

    // Concurrent write to 15 while reading 0.
    run('{1'b0, 1'b1, 4'd15, 8'h5A, 4'd0,
          8'h01, 8'h01}, "xport");
    chk("mem15", {24'h0, u8.mem[15]}, 32'h5A);
    idle_read(4'd15, 8'h5A, "rd15");
    idle_read(4'd9, 8'h0A, "rd9");

    // Reset with a competing write to 2.
    run('{1'b1, 1'b1, 4'd2, 8'hFF, 4'd2,
          8'h03, 8'h00}, "rst wr");
    for (int a = 0; a < 16; a++)
      idle_read(4'(a), 8'h00, $sformatf("clr%0d", a));

    // Held reset, then writes resume at once.
    run('{1'b1, 1'b0, 4'd0, 8'h00, 4'd5,
          8'h00, 8'h00}, "rst2");
    run('{1'b1, 1'b1, 4'd5, 8'h77, 4'd5,
          8'h00, 8'h00}, "rst3");
    run('{1'b0, 1'b1, 4'd5, 8'h77, 4'd5,
          8'h00, 8'h77}, "resume");
    idle_read(4'd2, 8'h00, "rd2 after");

    // Wide instance: single write pulse.
    @(negedge clk);
    c_wren = 1'b1; c_wa = 2'd1;
    c_d = 30'h2000_0001;
    @(negedge clk);
    c_wren = 1'b0; c_d = '0;
    for (int a = 0; a < 4; a++) begin
      c_ra = 2'(a);
      #1;
      chk($sformatf("w30 rd%0d", a), {2'b0, c_q},
          (a == 1) ? 32'h2000_0001 : 32'h0);
    end
    chk("w30 mem1", {2'b0, u30.mem[1]}, 32'h2000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
